// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle data-memory access stage. Takes the ALU result as a byte
//   address, formats stores (lane replication + byte strobes), runs a
//   req/ready handshake to word-organised memory and extends load data.
//   Stalls the core until the access completes, is rejected, or times out.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   MemRead, MemWrite     load / store request from the current instruction
//   funct3                access size / sign
//   ALUResult, ReadData2  byte address, store data
//   stall                 hold the core (combinational)
//   load_data             extended load result, valid in DONE
//   misalign, bus_err     one-cycle rejection / error pulses in DONE
//   mem_*                 word-organised memory request channel
//
// State table
//   S_IDLE | no access in flight; classify a new request
//   S_WAIT | request issued, waiting for mem_ready or timeout
//   S_DONE | one cycle with stall low; results and pulses valid
module load_store_unit #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [31:0]           ALUResult,
  input  logic [31:0]           ReadData2,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  misalign,
  output logic                  bus_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;

  logic        w_access, w_illegal, w_misalign, w_timeout;
  logic [31:0] w_wdata, w_ext;
  logic [3:0]  w_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Address bits above the word address are not decoded.
  logic        w_unused_addr;
  assign w_unused_addr = ^ALUResult[31:ADDR_WIDTH+2];

  assign w_access  = MemRead | MemWrite;
  assign w_illegal = (MemRead & MemWrite) | (funct3 == 3'b011) | (funct3 == 3'b110) |
                     (funct3 == 3'b111) | (MemWrite & funct3[2]);
  assign w_misalign = ((funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00)) ||
                      ((funct3[1:0] == 2'b01) && ALUResult[0]);
  assign w_timeout = (r_cnt == LP_LAST);

  // rst_n gating keeps stall low while reset is held even if the core
  // still presents a memory instruction.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_access & rst_n;
      S_WAIT:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = ReadData2;
    w_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        w_wdata = {4{ReadData2[7:0]}};
        w_wstrb = 4'b0001 << ALUResult[1:0];
      end
      2'b01: begin
        w_wdata = {2{ReadData2[15:0]}};
        w_wstrb = 4'b0011 << {ALUResult[1], 1'b0};
      end
      default: begin
        w_wdata = ReadData2;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'h0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'h0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_access) w_next = (w_illegal | w_misalign) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready | w_timeout) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_off     <= '0;
      r_f3      <= '0;
      load_data <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              bus_err   <= 1'b1;
              load_data <= '0;
            end else if (w_misalign) begin
              misalign  <= 1'b1;
              load_data <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= ALUResult[ADDR_WIDTH+1:2];
              mem_wdata <= w_wdata;
              mem_wstrb <= MemWrite ? w_wstrb : 4'b0000;
              r_off     <= ALUResult[1:0];
              r_f3      <= funct3;
              r_cnt     <= '0;
            end
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            load_data <= mem_we ? 32'h0 : w_ext;
          end else if (w_timeout) begin
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
